// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and RAM write port of the program loader
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // Stream source and RAM sink side
  modport master (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a checksummed byte image into the core RAM, holds core in reset until verified
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_req,
  prog_loader_if.slave     bus,
  output logic             core_reset,
  output logic             done,
  output logic             err
);

  // Word count must hold DEPTH itself, so it is one bit wider than the address
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_WR, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [NW-1:0]     n_q;
  logic [7:0]        lo_q;
  logic [7:0]        csum_q;
  logic [ADDR_W-1:0] addr_q;
  logic              xfer;
  logic              hdr_ok;
  logic              last_word;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign hdr_ok    = (bus.in_data != 8'd0) && (bus.in_data <= 8'(DEPTH));
  // Address stops at N-1, so the last word is recognised by address rather than a separate count
  assign last_word = (NW'(addr_q) == n_q - NW'(1));
  assign bus.ram_addr = addr_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; load_req is only honoured in the idle/terminal states
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (load_req) state_next = S_HDR;
      S_HDR:  if (xfer) state_next = hdr_ok ? S_LO : S_ERR;
      S_LO:   if (xfer) state_next = S_HI;
      S_HI:   if (xfer) state_next = S_WR;
      S_WR:   state_next = last_word ? S_CHK : S_LO;
      S_CHK:  if (xfer) state_next = (bus.in_data == csum_q) ? S_RUN : S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.in_ready <= 1'b0;
      bus.ram_we   <= 1'b0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.in_ready <= (state_next == S_HDR) || (state_next == S_LO) ||
                      (state_next == S_HI)  || (state_next == S_CHK);
      bus.ram_we   <= (state_next == S_WR);
      core_reset   <= (state_next != S_RUN);
      done         <= (state_next == S_RUN);
      err          <= (state_next == S_ERR);
    end
  end

  // Datapath: header capture, byte latches, running checksum and write address
  always_ff @(posedge clock) begin
    if (reset) begin
      n_q           <= '0;
      lo_q          <= '0;
      csum_q        <= '0;
      addr_q        <= '0;
      bus.ram_wdata <= '0;
    end else begin
      case (state)
        S_HDR: if (xfer && hdr_ok) begin
          n_q    <= bus.in_data[NW-1:0];
          csum_q <= bus.in_data;
          addr_q <= '0;
        end
        S_LO: if (xfer) begin
          lo_q   <= bus.in_data;
          csum_q <= csum_q ^ bus.in_data;
        end
        S_HI: if (xfer) begin
          bus.ram_wdata <= DATA_W'({bus.in_data, lo_q});
          csum_q        <= csum_q ^ bus.in_data;
        end
        S_WR: if (!last_word) addr_q <= addr_q + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule
